alu_nibble_seq: RTL
===================

// Module: alu_nibble_seq
// PURPOSE
//  Upstream sequencer for the 4-bit combinational alu. Accepts one WIDTH-bit op
//  via valid/ready, feeds it to the alu one nibble per cycle (LS nibble first),
//  chains alu Cout into the next slice's Cin, assembles the WIDTH-bit result and
//  returns it via valid/ready. Lets the 4-bit alu serve wider datapaths.
// PARAMETERS
//  WIDTH   16   operand/result width; multiple of 4, >= 4
//  (localparam NSLICE = WIDTH/4)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      op request valid
//  in_ready    out  1      block can accept op
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_cin      in   1      carry into slice 0
//  in_ctrl     in   3      alu Ctrl code, passed opaque to every slice
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  out_result  out  WIDTH  assembled result
//  out_cout    out  1      alu Cout of final slice
//  alu_A       out  4      to alu A
//  alu_B       out  4      to alu B
//  alu_Cin     out  1      to alu Cin
//  alu_Ctrl    out  3      to alu Ctrl
//  alu_Output  in   4      from alu Output
//  alu_Cout    in   1      from alu Cout
// BEHAVIOUR
//  - FSM IDLE -> RUN -> DONE -> IDLE. Reset (any state): IDLE, idx=0, result/cout
//    regs 0, out_valid=0. in_ready = (state==IDLE) & ~rst, combinational.
//  - IDLE: on in_valid & in_ready latch in_a/in_b/in_ctrl, carry<=in_cin, idx<=0,
//    go RUN. Inputs ignored whenever in_ready=0.
//  - RUN: alu_A=a_reg[4*idx+:4], alu_B=b_reg[4*idx+:4], alu_Cin=carry,
//    alu_Ctrl=ctrl_reg. Each edge: res[4*idx+:4]<=alu_Output, carry<=alu_Cout,
//    idx++. Edge with idx==NSLICE-1: capture, out_cout<=alu_Cout, go DONE.
//  - Carry chained for every Ctrl code; block does not interpret Ctrl.
//  - alu_A/alu_B/alu_Cin/alu_Ctrl drive 0 outside RUN.
//  - Latency: accept at edge k -> out_valid high after edge k+NSLICE.
//    WIDTH=4: single RUN cycle.
//  - DONE: out_valid=1; out_result/out_cout held stable until out_valid &
//    out_ready, then IDLE on that edge. No new op accepted in RUN or DONE.
//  - Back-to-back throughput: one op per NSLICE+2 cycles.
//  - rst mid-RUN/DONE: op discarded, no out_valid; IDLE on next cycle.
// TESTING (WIDTH=16; bench alu model: Ctrl 000 = A+B+Cin, 001 = A&B with Cout=0)
//  1. 0x00FF+0x0001, cin 0, ctrl 000 -> out_result 0x0100, out_cout 0; out_valid
//     rises 4 edges after accept; alu_Cin per slice 0,1,1,0.
//  2. 0xFFFF+0x0000, cin 1 -> 0x0000, out_cout 1; alu_Cin slices 1,1,1,1.
//  3. 0xF0F0 & 0x3C3C, ctrl 001 -> 0x3030, out_cout 0; alu_Ctrl=001 all 4 slices.
//  4. out_ready low 10 cycles in DONE -> out_valid stays 1, result stable,
//     in_ready 0, concurrent in_valid op not accepted.
//  5. rst high 1 cycle during slice 2 -> IDLE, out_valid never asserted,
//     in_ready 1 after rst low; following 0x1234+0x1111 returns 0x2345.
//  6. in_valid, out_ready held 1, 3 ops -> accepts spaced 6 cycles, results in order.

Source files
------------

// File: rtl/alu_nibble_seq.sv
// Sequencer that runs a WIDTH-bit operation through an external 4-bit alu,
// one nibble per cycle with carry chained between slices, LS nibble first.
module alu_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [2:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic [3:0]       alu_A,
  output logic [3:0]       alu_B,
  output logic             alu_Cin,
  output logic [2:0]       alu_Ctrl,
  input  logic [3:0]       alu_Output,
  input  logic             alu_Cout
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       ctrl_reg;
  logic             carry;
  logic [WIDTH-1:0] res;
  logic             cout_reg;
  logic             accept;
  logic             last;

  assign last       = (idx == IDXW'(NSLICE - 1));
  assign out_result = res;
  assign out_cout   = cout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      ctrl_reg <= '0;
      carry    <= 1'b0;
      res      <= '0;
      cout_reg <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            ctrl_reg <= in_ctrl;
            carry    <= in_cin;
            idx      <= '0;
          end
        end
        RUN: begin
          res[4*idx +: 4] <= alu_Output;
          carry           <= alu_Cout;
          // The final slice's carry becomes the op's carry-out; idx rewinds for the next op.
          if (last) begin
            cout_reg <= alu_Cout;
            idx      <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    alu_A      = 4'd0;
    alu_B      = 4'd0;
    alu_Cin    = 1'b0;
    alu_Ctrl   = 3'd0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept) next_state = RUN;
      end
      RUN: begin
        alu_A    = a_reg[4*idx +: 4];
        alu_B    = b_reg[4*idx +: 4];
        alu_Cin  = carry;
        alu_Ctrl = ctrl_reg;
        if (last) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
